// File: rtl/music_pkg.sv
// Shared constants for the music sequencer: note frequencies (Hz), FSM state codes,
// tone word width and the tempo-select helper.
package music_pkg;

    localparam int TONE_W = 32;

    localparam logic [TONE_W-1:0] NOTE_D3   = 32'd147;
    localparam logic [TONE_W-1:0] NOTE_E3   = 32'd165;
    localparam logic [TONE_W-1:0] NOTE_F3   = 32'd175;
    localparam logic [TONE_W-1:0] NOTE_A3   = 32'd220;
    localparam logic [TONE_W-1:0] NOTE_A4   = 32'd440;
    localparam logic [TONE_W-1:0] NOTE_B4   = 32'd494;
    localparam logic [TONE_W-1:0] NOTE_C5   = 32'd523;
    localparam logic [TONE_W-1:0] NOTE_D5   = 32'd587;
    localparam logic [TONE_W-1:0] NOTE_E5   = 32'd659;
    localparam logic [TONE_W-1:0] NOTE_F5   = 32'd698;
    localparam logic [TONE_W-1:0] NOTE_G5   = 32'd784;
    localparam logic [TONE_W-1:0] NOTE_A5   = 32'd880;
    localparam logic [TONE_W-1:0] NOTE_BB5  = 32'd932;
    // Above the audible band, so the note generators produce nothing useful.
    localparam logic [TONE_W-1:0] SILENCE   = 32'd20000;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PLAY  = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;

    function automatic logic [31:0] f_tempo_limit(input logic [31:0] div,
                                                  input logic [1:0]  sel);
        case (sel)
            2'd1:    f_tempo_limit = div >> 1;
            2'd2:    f_tempo_limit = div << 1;
            default: f_tempo_limit = div;
        endcase
    endfunction

endpackage

// File: rtl/music_score_rom.sv
// Score lookup: one 32-bit tone (Hz) per (channel, quarter-beat); purely combinational.
// Latency 0; no handshake. ch0 carries the melody, ch1 the bass, other channels and beats >= LEN are silent.
module music_score_rom
    import music_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int LEN    = 64,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int BEAT_W = $clog2(LEN)
) (
    input  logic [CH_W-1:0]   ch,
    input  logic [BEAT_W-1:0] beat,
    output logic [TONE_W-1:0] tone
);

    logic [31:0] w_idx;
    assign w_idx = 32'(beat);

    always_comb begin
        tone = SILENCE;
        if (w_idx < 32'(LEN)) begin
            if (ch == CH_W'(0)) begin
                // 16-step melody phrase repeated across the song
                case (w_idx[3:0])
                    4'd0:  tone = NOTE_A4;
                    4'd1:  tone = NOTE_C5;
                    4'd2:  tone = NOTE_E5;
                    4'd3:  tone = NOTE_A5;
                    4'd4:  tone = NOTE_G5;
                    4'd5:  tone = NOTE_E5;
                    4'd6:  tone = NOTE_D5;
                    4'd7:  tone = SILENCE;
                    4'd8:  tone = NOTE_F5;
                    4'd9:  tone = NOTE_A5;
                    4'd10: tone = NOTE_BB5;
                    4'd11: tone = NOTE_A5;
                    4'd12: tone = NOTE_G5;
                    4'd13: tone = NOTE_E5;
                    4'd14: tone = NOTE_C5;
                    default: tone = NOTE_B4;
                endcase
            end else if (ch == CH_W'(1)) begin
                // Bass holds each root for two beats (8 quarter-beats)
                case (w_idx[4:3])
                    2'd0:    tone = NOTE_A3;
                    2'd1:    tone = NOTE_F3;
                    2'd2:    tone = NOTE_D3;
                    default: tone = NOTE_E3;
                endcase
            end
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Multi-channel score sequencer with start/stop/pause, looping and end-of-song pulse; optional MUSIC_TEMPO_EN adds tempo_sel.
// Latency: playing/beat_num 1 cycle after start/stop; tone registered one cycle behind beat_num.
// No backpressure: control inputs are pulses/levels sampled every cycle, outputs are free-running registers.
module music_sequencer
    import music_pkg::*;
#(
    parameter logic [31:0] BEAT_DIV = 32'd12_500_000,
    parameter int          LEN      = 64,
    parameter int          NUM_CH   = 2,
    parameter int          BEAT_W   = $clog2(LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop_en,
`ifdef MUSIC_TEMPO_EN
    input  logic [1:0]               tempo_sel,
`endif
    output logic [BEAT_W-1:0]        beat_num,
    output logic [NUM_CH*TONE_W-1:0] tone,
    output logic                     playing,
    output logic                     done,
    output logic                     wrap
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                   r_state;
    logic [31:0]              r_div_cnt;
    logic [BEAT_W-1:0]        r_beat;
    logic [NUM_CH*TONE_W-1:0] r_tone;
    logic                     r_done;
    logic                     r_wrap;

    logic [NUM_CH*TONE_W-1:0] w_rom;
    logic [31:0]              w_limit;
    logic                     w_terminal;
    logic                     w_last;
    logic                     w_boundary;

    assign w_terminal = (r_div_cnt == w_limit - 32'd1);
    assign w_last     = (r_beat == BEAT_W'(LEN - 1));
    // End-of-song outranks pause; otherwise pause freezes even a terminal count.
    assign w_boundary = (r_state == ST_PLAY) && !stop && w_terminal && (w_last || !pause);

`ifdef MUSIC_TEMPO_EN
    logic [31:0] r_limit;

    // Reloaded only where a beat begins, so a tempo change never cuts a beat short.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_limit <= BEAT_DIV;
        end else if (((r_state == ST_IDLE) && start && !stop) || w_boundary) begin
            r_limit <= f_tempo_limit(BEAT_DIV, tempo_sel);
        end
    end

    assign w_limit = r_limit;
`else
    assign w_limit = BEAT_DIV;
`endif

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c = c + 1) begin : g_ch
            music_score_rom #(
                .NUM_CH (NUM_CH),
                .LEN    (LEN),
                .CH_W   (CH_W),
                .BEAT_W (BEAT_W)
            ) u_rom (
                .ch   (CH_W'(c)),
                .beat (r_beat),
                .tone (w_rom[c*TONE_W +: TONE_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= 32'd0;
            r_beat    <= '0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_div_cnt <= 32'd0;
                    r_beat    <= '0;
                    if (start && !stop) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_div_cnt <= 32'd0;
                        r_beat    <= '0;
                    end else if (w_boundary) begin
                        r_div_cnt <= 32'd0;
                        if (w_last) begin
                            r_beat <= '0;
                            if (loop_en) begin
                                r_wrap <= 1'b1;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end else if (pause) begin
                        r_state <= ST_PAUSE;
                    end else begin
                        r_div_cnt <= r_div_cnt + 32'd1;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        r_state   <= ST_IDLE;
                        r_div_cnt <= 32'd0;
                        r_beat    <= '0;
                    end else if (start && !pause) begin
                        r_state <= ST_PLAY;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_div_cnt <= 32'd0;
                    r_beat    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tone <= {NUM_CH{SILENCE}};
        end else begin
            r_tone <= (r_state == ST_PLAY) ? w_rom : {NUM_CH{SILENCE}};
        end
    end

    assign beat_num = r_beat;
    assign tone     = r_tone;
    assign playing  = (r_state == ST_PLAY);
    assign done     = r_done;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer (BEAT_DIV=4, LEN=32, NUM_CH=2): reset, stepping, end of song,
// looping, pause/resume, stop and mid-song reset; tempo select when MUSIC_TEMPO_EN is defined.
module tb_music_sequencer;

    localparam logic [31:0] SIL = 32'd20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        loop_en = 1'b0;
`ifdef MUSIC_TEMPO_EN
    logic [1:0]  tempo_sel = 2'd0;
`endif
    logic [4:0]  beat_num;
    logic [63:0] tone;
    logic        playing;
    logic        done;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    music_sequencer #(
        .BEAT_DIV (32'd4),
        .LEN      (32),
        .NUM_CH   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .loop_en   (loop_en),
`ifdef MUSIC_TEMPO_EN
        .tempo_sel (tempo_sel),
`endif
        .beat_num  (beat_num),
        .tone      (tone),
        .playing   (playing),
        .done      (done),
        .wrap      (wrap)
    );

    // Hand-written copy of the score: melody phrase on ch0, two-beat bass roots on ch1.
    function automatic logic [31:0] score(input int ch, input int b);
        logic [31:0] mel [16];
        logic [31:0] bas [4];
        mel = '{32'd440, 32'd523, 32'd659, 32'd880, 32'd784, 32'd659, 32'd587, 32'd20000,
                32'd698, 32'd880, 32'd932, 32'd880, 32'd784, 32'd659, 32'd523, 32'd494};
        bas = '{32'd220, 32'd175, 32'd147, 32'd165};
        if (b >= 32) return SIL;
        return (ch == 0) ? mel[b % 16] : bas[(b / 8) % 4];
    endfunction

    function automatic logic [63:0] exp_tone(input int b);
        return {score(1, b), score(0, b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        int  n;
        bit  got;

        // Reset values
        tick();
        tick();
        check("rst_beat", 64'(beat_num), 64'd0);
        check("rst_tone", tone, {SIL, SIL});
        check("rst_playing", 64'(playing), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_tone", tone, {SIL, SIL});

        // Start, beat stepping, one-cycle tone lag, full song to done
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_playing", 64'(playing), 64'd1);
        check("start_beat", 64'(beat_num), 64'd0);
        check("start_tone_sil", tone, {SIL, SIL});
        tick();
        check("tone_beat0", tone, exp_tone(0));
        tick();
        tick();
        tick();
        check("beat1", 64'(beat_num), 64'd1);
        check("lag_tone_b0", tone, exp_tone(0));
        tick();
        check("lag_tone_b1", tone, exp_tone(1));
        n = 5;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            n++;
            check("run_wrap", 64'(wrap), 64'd0);
            if (done) begin
                got = 1'b1;
            end else begin
                check("run_beat", 64'(beat_num), 64'(n / 4));
                check("run_tone", tone, exp_tone((n - 1) / 4));
            end
        end
        check("done_seen", 64'(got), 64'd1);
        check("done_cycle", 64'(n), 64'd128);
        check("done_beat", 64'(beat_num), 64'd0);
        check("done_playing", 64'(playing), 64'd0);
        check("done_tone_last", tone, exp_tone(31));
        tick();
        check("done_pulse_end", 64'(done), 64'd0);
        check("done_tone_sil", tone, {SIL, SIL});

        // Looping: wrap at 31 -> 0, stays in PLAY
        loop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (127) tick();
        check("loop_b31", 64'(beat_num), 64'd31);
        check("loop_nowrap", 64'(wrap), 64'd0);
        tick();
        check("loop_wrap", 64'(wrap), 64'd1);
        check("loop_beat0", 64'(beat_num), 64'd0);
        check("loop_playing", 64'(playing), 64'd1);
        check("loop_nodone", 64'(done), 64'd0);
        tick();
        check("loop_wrap_end", 64'(wrap), 64'd0);
        check("loop_tone0", tone, exp_tone(0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop_en = 1'b0;
        check("stop_playing", 64'(playing), 64'd0);
        check("stop_beat", 64'(beat_num), 64'd0);
        tick();
        check("stop_tone_sil", tone, {SIL, SIL});

        // Pause in beat 5 after one counted cycle, then resume
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (21) tick();
        check("pre_pause_b5", 64'(beat_num), 64'd5);
        pause = 1'b1;
        repeat (10) tick();
        check("pause_beat", 64'(beat_num), 64'd5);
        check("pause_playing", 64'(playing), 64'd0);
        check("pause_tone", tone, {SIL, SIL});
        start = 1'b1;
        tick();
        check("pause_start_ign", 64'(playing), 64'd0);
        pause = 1'b0;
        tick();
        start = 1'b0;
        check("resume_playing", 64'(playing), 64'd1);
        check("resume_beat", 64'(beat_num), 64'd5);
        tick();
        check("resume_tone", tone, exp_tone(5));
        check("resume_b5a", 64'(beat_num), 64'd5);
        tick();
        check("resume_b5b", 64'(beat_num), 64'd5);
        tick();
        check("resume_b6", 64'(beat_num), 64'd6);

        // stop and start together in PLAY
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        check("ss_playing", 64'(playing), 64'd0);
        check("ss_beat", 64'(beat_num), 64'd0);
        tick();
        check("ss_stay_idle", 64'(playing), 64'd0);
        check("ss_tone", tone, {SIL, SIL});

        // Reset mid-song at beat 17
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (68) tick();
        check("mid_b17", 64'(beat_num), 64'd17);
        tick();
        check("mid_tone17", tone, exp_tone(17));
        rst = 1'b1;
        tick();
        check("mid_rst_beat", 64'(beat_num), 64'd0);
        check("mid_rst_tone", tone, {SIL, SIL});
        check("mid_rst_playing", 64'(playing), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_wrap", 64'(wrap), 64'd0);
        rst = 1'b0;
        tick();

`ifdef MUSIC_TEMPO_EN
        // Half-length beats, then switch to double length mid-beat
        tempo_sel = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t1_b0", 64'(beat_num), 64'd0);
        tick();
        check("t1_b1", 64'(beat_num), 64'd1);
        tempo_sel = 2'd2;
        tick();
        check("t1_b1_hold", 64'(beat_num), 64'd1);
        tick();
        check("t2_b2", 64'(beat_num), 64'd2);
        repeat (7) tick();
        check("t2_b2_hold", 64'(beat_num), 64'd2);
        tick();
        check("t2_b3", 64'(beat_num), 64'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
